// File: rtl/vga_rx_if.sv
// vga_rx_if: display timing/pixel bus into the decoder and the capture write stream out of it.
interface vga_rx_if;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic [11:0] pix_data;
    logic        wr_en;
    logic        frame_start;
    logic        locked;
    logic        err;
    logic [9:0]  h_total_meas;
    logic [9:0]  v_total_meas;

    // Timing source side: drives sync/pixel bus, observes decoder results.
    modport master (
        output hsync, vsync, valid, vga_r, vga_g, vga_b,
        input  h_addr, v_addr, pix_data, wr_en, frame_start, locked, err,
               h_total_meas, v_total_meas
    );

    // Decoder side.
    modport slave (
        input  hsync, vsync, valid, vga_r, vga_g, vga_b,
        output h_addr, v_addr, pix_data, wr_en, frame_start, locked, err,
               h_total_meas, v_total_meas
    );
endinterface

// File: rtl/vga_rx.sv
// vga_rx: sink-side VGA timing decoder. Recovers pixel coordinates/data, measures line and
// frame timing, locks to the configured mode and emits a 12-bit pixel write stream.
// Optional feature macro: VGA_RX_LOCK_GATE_EN (when defined, pixel writes only while locked).
module vga_rx #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic    pclk,
    input  logic    reset,
    vga_rx_if.slave bus
);
    localparam int unsigned   CW      = 10;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] HT      = CW'(H_TOTAL);
    localparam logic [CW-1:0] VT      = CW'(V_TOTAL);
    localparam logic [CW-1:0] HA      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VA      = CW'(V_ACTIVE);

    typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

    state_t        state, state_nx;
    logic          hs1, vs1, de1, hs2, vs2, de2;
    logic [11:0]   pix1;
    logic          hs_fall, vs_fall, de_fall;
    logic [CW-1:0] p_cnt, l_cnt, x, y, y_inc;
    logic [CW-1:0] h_meas, v_meas, h_meas_nx;
    logic          px_bad, px_err, frame_ok, fail;
    logic          locked_nx, err_nx, wr_nx;
    logic [CW-1:0] h_addr_q, v_addr_q;
    logic [11:0]   pix_q;
    logic          wr_q, fs_q, lk_q, err_q;

    // Input capture plus a second copy of the sync/enable bits for edge detection.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            de1  <= 1'b0;
            hs2  <= 1'b0;
            vs2  <= 1'b0;
            de2  <= 1'b0;
            pix1 <= '0;
        end else begin
            hs1  <= bus.hsync;
            vs1  <= bus.vsync;
            de1  <= bus.valid;
            hs2  <= hs1;
            vs2  <= vs1;
            de2  <= de1;
            pix1 <= {bus.vga_r[7:4], bus.vga_g[7:4], bus.vga_b[7:4]};
        end
    end

    // Edge detect and frame/line checks, evaluated on the values being latched this cycle.
    always_comb begin
        hs_fall   = hs2 & ~hs1;
        vs_fall   = vs2 & ~vs1;
        de_fall   = de2 & ~de1;
        y_inc     = (de_fall && (y != CNT_MAX)) ? y + CW'(1) : y;
        h_meas_nx = hs_fall ? p_cnt : h_meas;
        px_err    = de_fall && (x != HA);
        frame_ok  = (h_meas_nx == HT) && (l_cnt == VT) && (y_inc == VA) && !px_bad && !px_err;
        fail      = (hs_fall && (p_cnt != HT)) || px_err || (vs_fall && !frame_ok)
                    || (p_cnt == CNT_MAX);
    end

    // Saturating period/line/column/row counters and the line/frame measurements.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            p_cnt  <= '0;
            l_cnt  <= '0;
            x      <= '0;
            y      <= '0;
            h_meas <= '0;
            v_meas <= '0;
            px_bad <= 1'b0;
        end else begin
            if (hs_fall) begin
                h_meas <= p_cnt;
                p_cnt  <= CW'(1);
            end else if (p_cnt != CNT_MAX) begin
                p_cnt <= p_cnt + CW'(1);
            end

            // A coincident hsync fall is the first line of the new frame.
            if (vs_fall) begin
                v_meas <= l_cnt;
                l_cnt  <= hs_fall ? CW'(1) : '0;
            end else if (hs_fall && (l_cnt != CNT_MAX)) begin
                l_cnt <= l_cnt + CW'(1);
            end

            if (de_fall) begin
                x <= '0;
            end else if (de1 && (x != CNT_MAX)) begin
                x <= x + CW'(1);
            end

            y <= vs_fall ? '0 : y_inc;

            if (vs_fall) begin
                px_bad <= 1'b0;
            end else if (px_err) begin
                px_bad <= 1'b1;
            end
        end
    end

    // Lock FSM state register.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state <= SEARCH;
        end else begin
            state <= state_nx;
        end
    end

    // Lock FSM next state.
    always_comb begin
        state_nx = state;
        case (state)
            SEARCH: if (vs_fall) state_nx = CHECK;
            CHECK:  if (vs_fall && frame_ok) state_nx = LOCKED;
            LOCKED: if (fail) state_nx = SEARCH;
            default: state_nx = SEARCH;
        endcase
    end

    // Lock FSM outputs, aligned with the pixel pipeline by registering them below.
    always_comb begin
        locked_nx = (state_nx == LOCKED);
        err_nx    = (state == LOCKED) && fail;
`ifdef VGA_RX_LOCK_GATE_EN
        wr_nx     = de1 && locked_nx;
`else
        wr_nx     = de1;
`endif
    end

    // Output register stage.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            h_addr_q <= '0;
            v_addr_q <= '0;
            pix_q    <= '0;
            wr_q     <= 1'b0;
            fs_q     <= 1'b0;
            lk_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            h_addr_q <= x;
            v_addr_q <= y;
            pix_q    <= pix1;
            wr_q     <= wr_nx;
            fs_q     <= vs_fall;
            lk_q     <= locked_nx;
            err_q    <= err_nx;
        end
    end

    assign bus.h_addr       = h_addr_q;
    assign bus.v_addr       = v_addr_q;
    assign bus.pix_data     = pix_q;
    assign bus.wr_en        = wr_q;
    assign bus.frame_start  = fs_q;
    assign bus.locked       = lk_q;
    assign bus.err          = err_q;
    assign bus.h_total_meas = h_meas;
    assign bus.v_total_meas = v_meas;
endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: randomized pixel stimulus on a reduced video mode, checked cycle by cycle
// against a frame/line-level reference model of the decoder.
module tb_vga_rx;
    localparam int HT  = 40;
    localparam int VT  = 12;
    localparam int HA  = 24;
    localparam int VA  = 8;
    localparam int HSW = 4;
    localparam int HA0 = 10;
    localparam int VA0 = 3;
`ifdef VGA_RX_LOCK_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    typedef struct packed {
        bit wr;
        bit fs;
        bit lk;
        bit er;
        int ha;
        int va;
        int pd;
        int hm;
        int vm;
    } exp_t;

    logic pclk  = 1'b0;
    logic reset = 1'b0;
    vga_rx_if bus ();

    vga_rx #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   iter    = 0;
    int   wr_seen = 0;
    int   err_seen = 0;
    exp_t h0, h1;

    // Reference model state: frame-level lock rules and timing measurements.
    bit exp_locked, armed, prev_hs, prev_vs, prev_de, px_bad;
    int last_hs, run, rows, lines, h_meas, v_meas;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input bit hs, input bit vs, input bit de);
        exp_locked = 1'b0;
        armed      = 1'b0;
        last_hs    = iter - 1;
        run        = 0;
        rows       = 0;
        lines      = 0;
        h_meas     = 0;
        v_meas     = 0;
        px_bad     = 1'b0;
        prev_hs    = hs;
        prev_vs    = vs;
        prev_de    = de;
    endtask

    task automatic model_step(input bit hs, input bit vs, input bit de,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit hsf, vsf, def, bad_new, ok, er;
        int pc, h_new, v_new, rows_new;
        exp_t e;
        hsf      = prev_hs && !hs;
        vsf      = prev_vs && !vs;
        def      = prev_de && !de;
        pc       = iter - last_hs;
        if (pc > 1023) pc = 1023;
        h_new    = hsf ? pc : h_meas;
        v_new    = vsf ? lines : v_meas;
        rows_new = rows + (def ? 1 : 0);
        bad_new  = px_bad || (def && run != HA);
        ok       = (h_new == HT) && (v_new == VT) && (rows_new == VA) && !bad_new;
        er       = 1'b0;
        e.ha     = run;
        e.va     = rows;
        e.pd     = int'({r[7:4], g[7:4], b[7:4]});
        if (exp_locked) begin
            if ((hsf && pc != HT) || (def && run != HA) || (vsf && !ok) || pc == 1023) begin
                exp_locked = 1'b0;
                armed      = 1'b0;
                er         = 1'b1;
            end
        end else if (vsf) begin
            if (armed && ok) exp_locked = 1'b1;
            armed = 1'b1;
        end
        if (hsf) begin
            h_meas  = pc;
            last_hs = iter;
        end
        if (vsf) begin
            v_meas = lines;
            lines  = hsf ? 1 : 0;
            rows   = 0;
            px_bad = 1'b0;
        end else begin
            if (hsf) lines++;
            rows   = rows_new;
            px_bad = bad_new;
        end
        if (def) run = 0;
        else if (de) run++;
        e.wr = de && (!GATE || exp_locked);
        e.fs = vsf;
        e.lk = exp_locked;
        e.er = er;
        e.hm = h_meas;
        e.vm = v_meas;
        h0 = e;
        prev_hs = hs;
        prev_vs = vs;
        prev_de = de;
    endtask

    // One pixel clock: check outputs due from two cycles back, then drive the next input.
    task automatic step(input bit hs, input bit vs, input bit de,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(posedge pclk);
        #1;
        check("locked", int'(bus.locked), int'(h1.lk));
        check("err", int'(bus.err), int'(h1.er));
        check("frame_start", int'(bus.frame_start), int'(h1.fs));
        check("wr_en", int'(bus.wr_en), int'(h1.wr));
        check("h_total_meas", int'(bus.h_total_meas), h1.hm);
        check("v_total_meas", int'(bus.v_total_meas), h1.vm);
        if (h1.wr) begin
            check("h_addr", int'(bus.h_addr), h1.ha);
            check("v_addr", int'(bus.v_addr), h1.va);
            check("pix_data", int'(bus.pix_data), h1.pd);
        end
        if (bus.wr_en) wr_seen++;
        if (bus.err) err_seen++;
        h1 = h0;
        bus.hsync = hs;
        bus.vsync = vs;
        bus.valid = de;
        bus.vga_r = r;
        bus.vga_g = g;
        bus.vga_b = b;
        if (!reset) begin
            model_clear(hs, vs, de);
            h0 = '0;
        end else begin
            model_step(hs, vs, de, r, g, b);
        end
        iter++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
    endtask

    // Drives nlines of a frame; line 'stretch' (if in range) gets one extra blanking cycle.
    task automatic frame(input int stretch, input int nlines);
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == stretch) ? HT + 1 : HT;
            for (int p = 0; p < len; p++) begin
                bit de;
                de = (l >= VA0) && (l < VA0 + VA) && (p >= HA0) && (p < HA0 + HA);
                if (de) step(p >= HSW, l >= 2, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
                else    step(p >= HSW, l >= 2, 1'b0, 8'h0, 8'h0, 8'h0);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"}, int'(bus.locked), 0);
        check({tag, "_wr_en"}, int'(bus.wr_en), 0);
        check({tag, "_h_addr"}, int'(bus.h_addr), 0);
        check({tag, "_pix_data"}, int'(bus.pix_data), 0);
        check({tag, "_h_total"}, int'(bus.h_total_meas), 0);
        check({tag, "_v_total"}, int'(bus.v_total_meas), 0);
    endtask

    initial begin
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.valid = 1'b0;
        bus.vga_r = 8'h0;
        bus.vga_g = 8'h0;
        bus.vga_b = 8'h0;
        h0 = '0;
        h1 = '0;
        model_clear(1'b1, 1'b1, 1'b0);
        idle(3);
        check_zero("reset");
        reset = 1'b1;
        idle(4);

        // Two vsync falls to lock; first frame is unlocked.
        wr_seen = 0;
        frame(-1, VT);
        check("wr_count_first", wr_seen, GATE ? 0 : HA * VA);
        check("locked_first", int'(bus.locked), 0);
        frame(-1, VT);
        check("locked_second", int'(bus.locked), 1);
        wr_seen = 0;
        frame(-1, VT);
        check("wr_count_locked", wr_seen, HA * VA);
        check("h_total", int'(bus.h_total_meas), HT);
        check("v_total", int'(bus.v_total_meas), VT);

        // One stretched line while locked, then relock after two clean vsync falls.
        err_seen = 0;
        frame(int'($urandom_range(10, 2)), VT);
        check("stretch_err_pulses", err_seen, 1);
        check("stretch_locked", int'(bus.locked), 0);
        frame(-1, VT);
        frame(-1, VT);
        check("relock_stretch", int'(bus.locked), 1);

        // hsync stuck high while locked.
        err_seen = 0;
        idle(1100);
        check("stuck_err_pulses", err_seen, 1);
        check("stuck_locked", int'(bus.locked), 0);
        check("stuck_h_total", int'(bus.h_total_meas), HT);
        frame(-1, VT);
        frame(-1, VT);
        frame(-1, VT);
        check("relock_stuck", int'(bus.locked), 1);

        // Asynchronous reset mid-frame.
        frame(-1, 5);
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        h0 = '0;
        h1 = '0;
        model_clear(bus.hsync, bus.vsync, bus.valid);
        idle(3);
        reset = 1'b1;
        idle(4);
        frame(-1, VT);
        check("reset_first", int'(bus.locked), 0);
        frame(-1, VT);
        frame(-1, 3);
        check("relock_reset", int'(bus.locked), 1);
        check("final_h_total", int'(bus.h_total_meas), HT);
        check("final_v_total", int'(bus.v_total_meas), VT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
